mips_muldiv_unit: RTL and testbench



---
 rtl/mips_muldiv_pkg.sv | 23 ++
 rtl/muldiv_shift_engine.sv | 81 ++++++++
 rtl/mips_muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op codes,
// FSM state encoding and op classification helper.
package mips_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Multiply and divide ops occupy the lower half of the op space.
  function automatic logic is_muldiv(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/muldiv_shift_engine.sv
// Iteration datapath for the multiply/divide unit. Works on unsigned
// magnitudes only: one shift-add multiply step or one restoring-divide
// step per enabled cycle, with a down-counter that marks the last step.
// The multiplier / dividend is loaded into the low word; the
// multiplicand / divisor is held in a separate operand register.
module muldiv_shift_engine #(
  parameter int WL = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  input  logic          is_div,
  input  logic [WL-1:0] a,
  input  logic [WL-1:0] b,
  output logic          last,
  output logic [WL-1:0] acc,
  output logic [WL-1:0] lsw
);

  localparam int CW = $clog2(WL + 1);

  logic [WL:0]   acc_q, acc_d;
  logic [WL-1:0] lsw_q, lsw_d;
  logic [WL-1:0] opnd_q, opnd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [WL:0]   sum;
  logic [WL:0]   shifted;
  logic          ge;

  // Next-state for the shift register: load, then one iteration per step.
  always_comb begin
    sum     = acc_q + {1'b0, opnd_q};
    shifted = {acc_q[WL-1:0], lsw_q[WL-1]};
    ge      = (shifted >= {1'b0, opnd_q});
    acc_d   = acc_q;
    lsw_d   = lsw_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    if (start) begin
      acc_d  = '0;
      lsw_d  = a;
      opnd_d = b;
      cnt_d  = CW'(WL);
    end else if (step) begin
      cnt_d = cnt_q - CW'(1);
      if (is_div) begin
        // Partial remainder is WL+1 bits wide after the shift.
        acc_d = ge ? (shifted - {1'b0, opnd_q}) : shifted;
        lsw_d = {lsw_q[WL-2:0], ge};
      end else if (lsw_q[0]) begin
        acc_d = {1'b0, sum[WL:1]};
        lsw_d = {sum[0], lsw_q[WL-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[WL:1]};
        lsw_d = {acc_q[0], lsw_q[WL-1:1]};
      end
    end
  end

  // Engine registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      lsw_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      lsw_q  <= lsw_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(1));
  assign acc  = acc_q[WL-1:0];
  assign lsw  = lsw_q;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Optional macro MULDIV_DIVZERO_FLAG_EN adds the registered dz output.
//
// state | meaning
// IDLE  | waiting; MTHI/MTLO complete here in one cycle
// RUN   | WL engine iterations on unsigned magnitudes
// FIX   | sign correction, HI/LO write, done pulse
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WL = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [WL-1:0] x,
  input  logic [WL-1:0] y,
  output logic          busy,
  output logic          done,
  output logic [WL-1:0] hi,
  output logic [WL-1:0] lo
`ifdef MULDIV_DIVZERO_FLAG_EN
  ,
  output logic          dz
`endif
);

  state_e        state_q, state_d;
  logic          is_div_q, is_div_d;
  logic          neg_res_q, neg_res_d;
  logic          neg_rem_q, neg_rem_d;
  logic          divz_q, divz_d;
  logic [WL-1:0] hi_q, hi_d;
  logic [WL-1:0] lo_q, lo_d;
  logic          done_q, done_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic          dz_q, dz_d;
`endif

  logic            signed_op, x_neg, y_neg;
  logic [WL-1:0]   x_mag, y_mag;
  logic            eng_start, eng_step, eng_last;
  logic [WL-1:0]   eng_acc, eng_lsw;
  logic [2*WL-1:0] prod, prod_fix;
  logic [WL-1:0]   quo_fix, rem_fix;

  muldiv_shift_engine #(.WL(WL)) u_engine (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (eng_start),
    .step   (eng_step),
    .is_div (is_div_q),
    .a      (x_mag),
    .b      (y_mag),
    .last   (eng_last),
    .acc    (eng_acc),
    .lsw    (eng_lsw)
  );

  // Operand magnitudes and sign-corrected results.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    x_neg     = signed_op & x[WL-1];
    y_neg     = signed_op & y[WL-1];
    x_mag     = x_neg ? -x : x;
    y_mag     = y_neg ? -y : y;
    prod      = {eng_acc, eng_lsw};
    prod_fix  = neg_res_q ? -prod : prod;
    quo_fix   = neg_res_q ? -eng_lsw : eng_lsw;
    rem_fix   = neg_rem_q ? -eng_acc : eng_acc;
  end

  // FSM next-state, HI/LO writes and done/dz generation.
  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
    dz_d      = 1'b0;
`endif
    eng_start = 1'b0;
    eng_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MTHI) begin
            hi_d   = x;
            done_d = 1'b1;
          end else if (op == OP_MTLO) begin
            lo_d   = x;
            done_d = 1'b1;
          end else if (is_muldiv(op)) begin
            eng_start = 1'b1;
            is_div_d  = op[1];
            neg_res_d = x_neg ^ y_neg;
            neg_rem_d = x_neg;
            divz_d    = (y == '0);
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        eng_step = 1'b1;
        if (eng_last) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          // Divide by zero yields hi=x naturally; lo is forced to all ones.
          hi_d = rem_fix;
          lo_d = divz_q ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*WL-1:WL];
          lo_d = prod_fix[WL-1:0];
        end
        done_d  = 1'b1;
`ifdef MULDIV_DIVZERO_FLAG_EN
        dz_d    = is_div_q & divz_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
      dz_q      <= dz_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
  assign dz   = dz_q;
`endif

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit (WL=32): vector table plus scoreboard queue,
// with hand sequences for busy-ignore, back-to-back, reserved op and reset.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  localparam int WL = 32;

  typedef struct {
    logic [2:0]    op;
    logic [WL-1:0] x;
    logic [WL-1:0] y;
    logic [WL-1:0] hi;
    logic [WL-1:0] lo;
    logic          dz;
  } vec_t;

  typedef struct {
    logic [WL-1:0] hi;
    logic [WL-1:0] lo;
    logic          dz;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [WL-1:0] x, y;
  logic          busy, done;
  logic [WL-1:0] hi, lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic          dz;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_seen = 0;
  exp_t sb_q[$];
  vec_t vecs[15];

  mips_muldiv_unit #(.WL(WL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
`ifdef MULDIV_DIVZERO_FLAG_EN
    ,
    .dz    (dz)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (busy) busy_seen++;
  endtask

  // Drive one request at the current negedge; it is accepted at the next posedge.
  task automatic issue(input logic [2:0] o, input logic [WL-1:0] a, input logic [WL-1:0] b,
                       input logic [WL-1:0] eh, input logic [WL-1:0] el, input logic edz);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz;
    sb_q.push_back(e);
    start = 1'b1; op = o; x = a; y = b;
    busy_seen = 0;
    tick();
    start = 1'b0;
    x = $urandom;
    y = $urandom;
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    exp_t e;
    int   guard = 0;
    while (!done && guard < WL * 4) begin
      tick();
      guard++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'(1));
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_nonempty"}, 64'(sb_q.size()), 64'(1));
    end else begin
      e = sb_q.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e.hi));
      check({tag, "_lo"}, 64'(lo), 64'(e.lo));
`ifdef MULDIV_DIVZERO_FLAG_EN
      check({tag, "_dz"}, 64'(dz), 64'(e.dz));
`endif
    end
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    check({tag, "_busy_cycles"}, 64'(busy_seen), 64'(exp_busy));
  endtask

  initial begin
    logic [WL-1:0]        ra, rb, eh, el, hi_keep;
    logic [63:0]          ea, eb, p;
    logic signed [WL-1:0] sa, sb, sq, sr;
    logic [2:0]           ro;
    int                   dcount;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{OP_MULT,  32'd0,        32'h12345678, 32'd0,        32'd0,        1'b0};
    vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{OP_MTHI,  32'hA5A5A5A5, 32'd0,        32'hA5A5A5A5, 32'h00000000, 1'b0};
    vecs[10] = '{OP_MTLO,  32'h5A5A5A5A, 32'd9,        32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0};
    vecs[11] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[12] = '{OP_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
    vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[14] = '{OP_MULTU, 32'h12345678, 32'd0,        32'd0,        32'd0,        1'b0};

    rst_n = 1'b0; start = 1'b0; op = '0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    rst_n = 1'b1;
    tick();

    // Table vectors
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].hi, vecs[i].lo, vecs[i].dz);
      wait_done($sformatf("vec%0d", i), vecs[i].op[2] ? 0 : WL + 1);
      tick();
      check($sformatf("vec%0d_done_width", i), 64'(done), 64'(0));
      check($sformatf("vec%0d_hold", i), {32'(hi), 32'(lo)}, {32'(vecs[i].hi), 32'(vecs[i].lo)});
`ifdef MULDIV_DIVZERO_FLAG_EN
      check($sformatf("vec%0d_dz_clear", i), 64'(dz), 64'(0));
`endif
    end

    // Random ops against an arithmetic reference model
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (ro[1] && (rb == '0 || (ro == OP_DIV && ra == 32'h80000000 && rb == '1))) rb = 32'd3;
      sa = ra; sb = rb;
      case (ro)
        OP_MULT: begin
          ea = {{32{ra[31]}}, ra}; eb = {{32{rb[31]}}, rb}; p = ea * eb;
          eh = p[63:32]; el = p[31:0];
        end
        OP_MULTU: begin
          p = {32'd0, ra} * {32'd0, rb};
          eh = p[63:32]; el = p[31:0];
        end
        OP_DIV: begin
          sq = sa / sb; sr = sa % sb;
          eh = sr; el = sq;
        end
        default: begin
          eh = ra % rb; el = ra / rb;
        end
      endcase
      issue(ro, ra, rb, eh, el, 1'b0);
      wait_done($sformatf("rand%0d", i), WL + 1);
    end

    // Busy-ignore: MTHI during a multiply is dropped
    issue(OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);
    repeat (3) tick();
    start = 1'b1; op = OP_MTHI; x = 32'hA5A5A5A5;
    tick();
    start = 1'b0;
    wait_done("busy_ignore", WL + 1);
    // Back-to-back: MTHI issued in the done cycle
    issue(OP_MTHI, 32'hA5A5A5A5, 32'd0, 32'hA5A5A5A5, 32'h00000000, 1'b0);
    wait_done("b2b_mthi", 0);
    tick();
    check("b2b_done_width", 64'(done), 64'(0));
    check("b2b_busy_low", 64'(busy), 64'(0));

    // Reserved op: no state change, no done
    start = 1'b1; op = 3'b110; x = 32'h11111111;
    tick();
    start = 1'b0;
    check("reserved_busy", 64'(busy), 64'(0));
    check("reserved_done", 64'(done), 64'(0));
    check("reserved_hi", 64'(hi), 64'(32'hA5A5A5A5));
    tick();
    check("reserved_done2", 64'(done), 64'(0));

    // Reset in the middle of a divide
    hi_keep = hi;
    start = 1'b1; op = OP_DIV; x = 32'd100; y = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre_reset_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
`ifdef MULDIV_DIVZERO_FLAG_EN
    check("rst_dz", 64'(dz), 64'(0));
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < WL + 5; c++) begin
      tick();
      if (done) dcount++;
    end
    check("rst_no_done", 64'(dcount), 64'(0));
    check("rst_hi_stays_clear", 64'(hi == hi_keep), 64'(0));
    issue(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    wait_done("post_reset", WL + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
